// File: rtl/mux_rr_reg.sv
// Registered N-channel mux with valid/ready handshakes: fixed-select (mode 0) or
// round-robin over valid channels (mode 1), feeding a single output register.
module mux_rr_reg #(
  parameter int N_CH  = 3,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_valid,
  output logic [N_CH-1:0]     in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  output logic [SEL_W-1:0]    out_ch,
  input  logic                out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  // One extra bit so the range check still works when 2**SEL_W == N_CH.
  localparam logic [SEL_W:0]   NCH_EXT = (SEL_W + 1)'(N_CH);
  localparam int unsigned      NCH_U   = N_CH;

  logic [SEL_W-1:0] ptr;
  logic             load_en;
  logic [SEL_W-1:0] fix_ch;
  logic [SEL_W-1:0] rr_ch;
  logic             rr_found;
  logic [SEL_W-1:0] ch;
  logic             grant_vld;
  logic             ch_valid;
  logic [W-1:0]     ch_data;
  logic             xfer;

  assign load_en = !out_valid || out_ready;

  assign fix_ch = ({1'b0, sel} < NCH_EXT) ? sel : LAST_CH;

  // Scan ptr, ptr+1, ... wrapping at N_CH; the first valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      int unsigned idx;
      idx = 32'(ptr) + i;
      if (idx >= NCH_U) idx = idx - NCH_U;
      for (int unsigned k = 0; k < NCH_U; k++) begin
        if (!rr_found && (k == idx) && in_valid[k]) begin
          rr_found = 1'b1;
          rr_ch    = SEL_W'(k);
        end
      end
    end
  end

  assign ch        = mode ? rr_ch : fix_ch;
  assign grant_vld = mode ? rr_found : 1'b1;

  always_comb begin
    ch_valid = 1'b0;
    ch_data  = '0;
    in_ready = '0;
    for (int unsigned k = 0; k < NCH_U; k++) begin
      if (ch == SEL_W'(k)) begin
        ch_valid    = in_valid[k];
        ch_data     = in_data[k*W +: W];
        in_ready[k] = grant_vld && load_en;
      end
    end
  end

  assign xfer = grant_vld && load_en && ch_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_data  <= ch_data;
        out_ch    <= ch;
        out_valid <= 1'b1;
        if (mode) ptr <= (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed, table-driven bench for mux_rr_reg (N_CH=3, W=8, SEL_W=2).
module tb_mux_rr_reg;

  logic        clk;
  logic        rst_n;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  mux_rr_reg #(.N_CH(3), .W(8), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [2:0] iv;
    logic [7:0] d0, d1, d2;
    logic       ordy;
    logic [2:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_och;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic m, input logic [1:0] s, input logic [2:0] iv,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                     input logic ordy, input logic [2:0] rdy, input logic ov,
                     input logic [7:0] od, input logic [1:0] och);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_och = och;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [2:0] iv,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic ordy);
    mode = m; sel = s; in_valid = iv; in_data = {d2, d1, d0}; out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);

    //   mode sel iv      d0     d1     d2     ordy rdy     ov    od     och
    // mode 0 fixed select, out-of-range select, invalid selected channel
    add(1'b0, 2'd1, 3'b111, 8'h11, 8'hA5, 8'h33, 1'b1, 3'b010, 1'b1, 8'hA5, 2'd1);
    add(1'b0, 2'd3, 3'b111, 8'h11, 8'h22, 8'hC3, 1'b1, 3'b100, 1'b1, 8'hC3, 2'd2);
    add(1'b0, 2'd3, 3'b011, 8'h11, 8'h22, 8'hEE, 1'b1, 3'b100, 1'b0, 8'hC3, 2'd2);
    add(1'b0, 2'd2, 3'b000, 8'h11, 8'h22, 8'h33, 1'b0, 3'b100, 1'b0, 8'hC3, 2'd2);
    // mode 1, all valid: 0,1,2,0
    add(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0);
    add(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1);
    add(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2);
    add(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0);
    // mode 1, iv=101 with ptr=1: 2,0,2
    add(1'b1, 2'd0, 3'b101, 8'h11, 8'h22, 8'h33, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2);
    add(1'b1, 2'd0, 3'b101, 8'h11, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0);
    add(1'b1, 2'd0, 3'b101, 8'h11, 8'h22, 8'h33, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2);
    // mode 1, nothing valid: no grant
    add(1'b1, 2'd0, 3'b000, 8'h11, 8'h22, 8'h33, 1'b1, 3'b000, 1'b0, 8'h33, 2'd2);
    // backpressure: load 5A, stall 4 cycles, then refill on drain
    add(1'b0, 2'd1, 3'b111, 8'h11, 8'h5A, 8'h33, 1'b0, 3'b010, 1'b1, 8'h5A, 2'd1);
    add(1'b1, 2'd0, 3'b111, 8'h77, 8'h22, 8'h33, 1'b0, 3'b000, 1'b1, 8'h5A, 2'd1);
    add(1'b1, 2'd0, 3'b111, 8'h77, 8'h22, 8'h33, 1'b0, 3'b000, 1'b1, 8'h5A, 2'd1);
    add(1'b1, 2'd0, 3'b111, 8'h77, 8'h22, 8'h33, 1'b0, 3'b000, 1'b1, 8'h5A, 2'd1);
    add(1'b1, 2'd0, 3'b111, 8'h77, 8'h22, 8'h33, 1'b0, 3'b000, 1'b1, 8'h5A, 2'd1);
    add(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0);
    // mode-0 transfer leaves ptr (=1) untouched
    add(1'b0, 2'd2, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2);
    add(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1);
    add(1'b0, 2'd0, 3'b001, 8'h44, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1, 8'h44, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data",  32'(out_data),  32'd0);
    chk("reset out_ch",    32'(out_ch),    32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].iv, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_od));
      chk($sformatf("v%0d out_ch", i),    32'(out_ch),    32'(vecs[i].exp_och));
    end

    // Asynchronous reset mid-stream: beat 44 is held, ptr is 2 at this point.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data",  32'(out_data),  32'd0);
    chk("async rst out_ch",    32'(out_ch),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After release, round-robin must restart at channel 0.
    drive(1'b1, 2'd0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("post-rst out_valid", 32'(out_valid), 32'd1);
    chk("post-rst out_data",  32'(out_data),  32'h11);
    chk("post-rst out_ch",    32'(out_ch),    32'd0);
    #1;
    chk("post-rst in_ready 2", 32'(in_ready), 32'b010);
    @(posedge clk);
    #1;
    chk("post-rst out_ch 2", 32'(out_ch), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
